// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_byte_tx between N_REQ byte producers.
// Optional SEND-phase watchdog is compiled in when UART_ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | sample req_valid, grant the next pending requester round-robin
// SEND  | en_send held high with a stable byte until uart_tx_done (or watchdog abort)
// GAP   | one cycle with en_send low so uart_byte_tx re-arms
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 600000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           req_done,
  output logic                       uart_en_send,
  output logic [DATA_W-1:0]          uart_data_byte,
  input  logic                       uart_tx_done,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       timeout_err
);

  localparam int GW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("uart_tx_arbiter: illegal parameter values");
  end

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t              state, state_nxt;
  logic [GW-1:0]       last_grant, grant_nxt;
  logic [DATA_W-1:0]   byte_nxt;
  logic                en_nxt;
  logic [N_REQ-1:0]    ready_nxt, done_nxt;
  logic                terr_nxt;
  logic [GW-1:0]       pick, idx;
  logic                pick_ok;
  logic                timeout_hit;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] send_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != SEND) send_cnt <= '0;
    else                      send_cnt <= send_cnt + 1'b1;
  end

  assign timeout_hit = (send_cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Scan from the farthest candidate back to last_grant+1 so the nearest one wins.
  always_comb begin
    pick    = last_grant;
    pick_ok = 1'b0;
    idx     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_grant) + k) % N_REQ);
      if (req_valid[idx]) begin
        pick    = idx;
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = last_grant;
    byte_nxt  = uart_data_byte;
    en_nxt    = uart_en_send;
    ready_nxt = '0;
    done_nxt  = '0;
    terr_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_ok) begin
          state_nxt       = SEND;
          grant_nxt       = pick;
          byte_nxt        = req_data[pick*DATA_W +: DATA_W];
          en_nxt          = 1'b1;
          ready_nxt[pick] = 1'b1;
        end
      end
      SEND: begin
        if (uart_tx_done) begin
          en_nxt               = 1'b0;
          done_nxt[last_grant] = 1'b1;
          state_nxt            = GAP;
        end else if (timeout_hit) begin
          en_nxt    = 1'b0;
          terr_nxt  = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_grant     <= GW'(N_REQ - 1);
      uart_data_byte <= '0;
      uart_en_send   <= 1'b0;
      req_ready      <= '0;
      req_done       <= '0;
      timeout_err    <= 1'b0;
    end else begin
      state          <= state_nxt;
      last_grant     <= grant_nxt;
      uart_data_byte <= byte_nxt;
      uart_en_send   <= en_nxt;
      req_ready      <= ready_nxt;
      req_done       <= done_nxt;
      timeout_err    <= terr_nxt;
    end
  end

  assign busy     = (state != IDLE);
  assign grant_id = last_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic           uart_tx_done = 1'b0;
  logic [N-1:0]   req_ready, req_done;
  logic           uart_en_send, busy, timeout_err;
  logic [W-1:0]   uart_data_byte;
  logic [1:0]     grant_id;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .req_done(req_done), .uart_en_send(uart_en_send),
    .uart_data_byte(uart_data_byte), .uart_tx_done(uart_tx_done), .busy(busy),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc    = 0;

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte is either in flight, in its one-cycle cool-down, or the
  // arbiter is free to grant the nearest pending requester after the last one served.
  bit           m_active, m_cool, m_found;
  int           m_lg;
  logic [N-1:0] exp_ready, exp_done;
  logic         exp_en, exp_terr;
  logic [W-1:0] exp_byte;
`ifdef UART_ARB_TIMEOUT_EN
  int           m_scnt;
`endif

  always @(posedge clk) begin
    exp_ready = '0;
    exp_done  = '0;
    exp_terr  = 1'b0;
    if (rst) begin
      m_active = 0; m_cool = 0; m_lg = N - 1; exp_en = 1'b0; exp_byte = '0;
    end else if (m_active) begin
`ifdef UART_ARB_TIMEOUT_EN
      m_scnt++;
`endif
      if (uart_tx_done) begin
        exp_done[m_lg] = 1'b1; m_active = 0; m_cool = 1; exp_en = 1'b0;
      end
`ifdef UART_ARB_TIMEOUT_EN
      else if (m_scnt == TO) begin
        exp_terr = 1'b1; m_active = 0; m_cool = 1; exp_en = 1'b0;
      end
`endif
    end else if (m_cool) begin
      m_cool = 0;
    end else begin
      m_found = 0;
      for (int k = 1; k <= N; k++) begin
        if (!m_found && req_valid[(m_lg + k) % N]) begin
          m_found = 1;
          m_lg = (m_lg + k) % N;
        end
      end
      if (m_found) begin
        exp_ready[m_lg] = 1'b1;
        exp_byte = req_data[m_lg*W +: W];
        exp_en = 1'b1;
        m_active = 1;
`ifdef UART_ARB_TIMEOUT_EN
        m_scnt = 0;
`endif
      end
    end
  end

  always @(negedge clk) begin
    chk("m_ready", req_ready, exp_ready);
    chk("m_done", req_done, exp_done);
    chk("m_en_send", uart_en_send, exp_en);
    chk("m_data_byte", uart_data_byte, exp_byte);
    chk("m_busy", busy, m_active | m_cool);
    chk("m_grant_id", grant_id, m_lg);
    chk("m_timeout_err", timeout_err, exp_terr);
    chk("ready_onehot0", $onehot0(req_ready), 1);
    chk("done_onehot0", $onehot0(req_done), 1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(output int gid);
    bit ok = 0;
    gid = -1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        ok = 1;
        for (int j = 0; j < N; j++) if (req_ready[j]) gid = j;
      end
    end
    chk("wait_ready_in_budget", ok, 1);
  endtask

  task automatic pulse_done();
    uart_tx_done = 1'b1;
    tick(1);
    uart_tx_done = 1'b0;
  endtask

  int         order[8]     = '{0, 1, 2, 3, 0, 1, 2, 3};
  logic [7:0] exp_bytes[8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h50, 8'h51, 8'h52, 8'h53};
  logic [7:0] cur_data[N];
  int         g, last_done, seen, c0;
  bit         got;

  initial begin
    tick(3);
    chk("rst_en_send", uart_en_send, 0);
    chk("rst_data_byte", uart_data_byte, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 3);
    chk("rst_ready_done", {req_ready, req_done, timeout_err}, 0);
    rst = 1'b0;

    // Single requester
    req_data[2*W +: W] = 8'hA5;
    req_valid = 4'b0100;
    wait_ready(g);
    chk("single_ready", req_ready, 4'b0100);
    chk("single_en_send", uart_en_send, 1);
    chk("single_byte", uart_data_byte, 8'hA5);
    chk("single_grant", grant_id, 2);
    req_valid = '0;
    tick(20);
    pulse_done();
    chk("single_done", req_done, 4'b0100);
    chk("single_en_low_done", uart_en_send, 0);
    tick(1);
    chk("single_en_low_gap", uart_en_send, 0);
    tick(1);
    chk("single_idle_busy", busy, 0);

    // Spurious tx_done while idle
    pulse_done();
    chk("spurious_done", req_done, 0);
    chk("spurious_en", uart_en_send, 0);
    tick(2);

    // Contention after fresh reset: strict rotation
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      cur_data[i] = 8'h10 + 8'(i);
      req_data[i*W +: W] = cur_data[i];
    end
    req_valid = 4'b1111;
    last_done = -100;
    for (int b = 0; b < 8; b++) begin
      wait_ready(g);
      chk("rr_grant", g, order[b]);
      chk("rr_byte", uart_data_byte, exp_bytes[b]);
      if (b > 0) chk("rr_spacing_ge3", (ncyc - last_done) >= 3, 1);
      if (g >= 0) begin
        cur_data[g] = cur_data[g] + 8'h40;
        req_data[g*W +: W] = cur_data[g];
      end
      if (b == 7) req_valid = '0;
      tick(4);
      last_done = ncyc;
      pulse_done();
    end
    tick(2);

    // Reset in the middle of SEND
    req_valid = 4'b0010;
    wait_ready(g);
    chk("pre_rst_grant", g, 1);
    req_valid = '0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_en_send", uart_en_send, 0);
    chk("midrst_done", req_done, 0);
    chk("midrst_grant", grant_id, 3);
    chk("midrst_busy", busy, 0);
    req_valid = 4'b0011;
    wait_ready(g);
    chk("post_rst_grant", g, 0);

    // Requester 1 withdraws during requester 0's SEND
    tick(2);
    req_valid = '0;
    tick(3);
    pulse_done();
    chk("drop_done_req0", req_done, 4'b0001);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req_ready[1]) seen++;
    end
    chk("drop_never_granted", seen, 0);

`ifdef UART_ARB_TIMEOUT_EN
    req_valid = 4'b0100;
    wait_ready(g);
    chk("to_grant", g, 2);
    c0 = ncyc;
    req_valid = '0;
    got = 0;
    seen = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_done != '0) seen++;
      if (timeout_err) got = 1;
    end
    chk("to_pulse_seen", got, 1);
    chk("to_send_cycles", ncyc - c0, TO);
    chk("to_no_done", seen, 0);
    chk("to_en_low", uart_en_send, 0);
    req_valid = 4'b1000;
    wait_ready(g);
    chk("to_next_grant", g, 3);
    req_valid = '0;
    tick(3);
    pulse_done();
`else
    req_valid = 4'b0100;
    wait_ready(g);
    req_valid = '0;
    tick(40);
    chk("no_to_still_sending", uart_en_send, 1);
    chk("no_to_err", timeout_err, 0);
    pulse_done();
    chk("no_to_done", req_done, 4'b0100);
`endif
    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: reached %0t without finishing", $time);
    $fatal(1, "time limit");
  end

endmodule
